// File: rtl/cache_sim_pkg.sv
// cache_sim_pkg: shared arbiter state encoding and sizing helpers for the refill path.
package cache_sim_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_ISSUE,
        ARB_WAIT,
        ARB_DONE
    } arb_state_e;

    function automatic int block_bits(input int block_size_byte);
        return block_size_byte * 8;
    endfunction

    function automatic int idx_w(input int num_cores);
        return (num_cores > 1) ? $clog2(num_cores) : 1;
    endfunction

endpackage

// File: rtl/rr_picker.sv
// rr_picker: rotate-priority encoder, returns the first set request at or after ptr (wrapping).
module rr_picker #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [IW-1:0] idx_o,
    output logic          valid_o
);

    // Scan offsets from farthest to nearest so the nearest set request is the last one written.
    always_comb begin
        idx_o = ptr_i;
        for (int i = N - 1; i >= 0; i--) begin
            if (req_i[(int'(ptr_i) + i) % N]) idx_o = IW'((int'(ptr_i) + i) % N);
        end
        valid_o = |req_i;
    end

endmodule

// File: rtl/refill_arbiter.sv
// refill_arbiter: round-robin sharing of one memory refill port among NUM_CORES caches.
// Optional statistics counters (grant_cnt, stall_cnt) are built when REFILL_ARB_STATS_EN is defined.
module refill_arbiter
    import cache_sim_pkg::*;
#(
    parameter int NUM_CORES       = 4,
    parameter int ADDR_W          = 32,
    parameter int BLOCK_SIZE_BYTE = 16,
    parameter int WAIT_MAX        = 255
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic [NUM_CORES-1:0]              core_req,
    input  logic [NUM_CORES*ADDR_W-1:0]       core_addr,
    output logic [NUM_CORES-1:0]              core_grant,
    output logic [NUM_CORES-1:0]              core_done,
    output logic                              core_err,
    output logic [block_bits(BLOCK_SIZE_BYTE)-1:0] core_block,
    output logic                              mem_start,
    output logic [ADDR_W-1:0]                 mem_addr,
    input  logic [block_bits(BLOCK_SIZE_BYTE)-1:0] mem_block,
    input  logic                              mem_ready,
    output logic                              busy
`ifdef REFILL_ARB_STATS_EN
    ,
    output logic [NUM_CORES*16-1:0]           grant_cnt,
    output logic [15:0]                       stall_cnt
`endif
);

    localparam int BB = block_bits(BLOCK_SIZE_BYTE);
    localparam int IW = idx_w(NUM_CORES);
    localparam int CW = (WAIT_MAX < 2) ? 1 : $clog2(WAIT_MAX);
    localparam logic [CW-1:0] CNT_LAST = (WAIT_MAX == 0) ? '0 : CW'(WAIT_MAX - 1);
    localparam logic [NUM_CORES-1:0] ONE = 1;

    arb_state_e           state_q, state_d;
    logic [IW-1:0]        rr_q, rr_d;
    logic [IW-1:0]        win_q, win_d;
    logic [NUM_CORES-1:0] grant_q, grant_d;
    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic [BB-1:0]        block_q, block_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 err_q, err_d;
    logic [IW-1:0]        pick_idx;
    logic                 pick_valid;

    rr_picker #(.N(NUM_CORES), .IW(IW)) u_picker (
        .req_i   (core_req),
        .ptr_i   (rr_q),
        .idx_o   (pick_idx),
        .valid_o (pick_valid)
    );

    // State and datapath registers; reset returns everything to idle with no done pulse.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ARB_IDLE;
            rr_q    <= '0;
            win_q   <= '0;
            grant_q <= '0;
            addr_q  <= '0;
            block_q <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            win_q   <= win_d;
            grant_q <= grant_d;
            addr_q  <= addr_d;
            block_q <= block_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    // Next-state: grant in IDLE, strobe in ISSUE, wait for data or timeout, then release in DONE.
    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        win_d   = win_q;
        grant_d = grant_q;
        addr_d  = addr_q;
        block_d = block_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        case (state_q)
            ARB_IDLE: begin
                if (pick_valid) begin
                    win_d   = pick_idx;
                    grant_d = ONE << pick_idx;
                    addr_d  = core_addr[pick_idx*ADDR_W +: ADDR_W];
                    state_d = ARB_ISSUE;
                end
            end
            ARB_ISSUE: begin
                cnt_d   = '0;
                err_d   = 1'b0;
                state_d = ARB_WAIT;
            end
            ARB_WAIT: begin
                if (mem_ready) begin
                    block_d = mem_block;
                    grant_d = '0;
                    state_d = ARB_DONE;
                end else if (WAIT_MAX != 0 && cnt_q == CNT_LAST) begin
                    err_d   = 1'b1;
                    grant_d = '0;
                    state_d = ARB_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ARB_DONE: begin
                rr_d    = (win_q == IW'(NUM_CORES - 1)) ? '0 : win_q + 1'b1;
                state_d = ARB_IDLE;
            end
        endcase
    end

    assign core_grant = grant_q;
    assign mem_addr   = addr_q;
    assign core_block = block_q;
    assign mem_start  = (state_q == ARB_ISSUE);
    assign busy       = (state_q != ARB_IDLE);
    assign core_done  = (state_q == ARB_DONE) ? (ONE << win_q) : '0;
    assign core_err   = (state_q == ARB_DONE) && err_q;

`ifdef REFILL_ARB_STATS_EN
    logic [NUM_CORES*16-1:0] gcnt_q;
    logic [15:0]             stall_q;

    // Per-core completion counters and a sanity counter for requests left unserved in IDLE.
    always_ff @(posedge clock) begin
        if (reset) begin
            gcnt_q  <= '0;
            stall_q <= '0;
        end else begin
            if (state_q == ARB_DONE) gcnt_q[win_q*16 +: 16] <= gcnt_q[win_q*16 +: 16] + 16'd1;
            if (state_q == ARB_IDLE && |core_req && !pick_valid) stall_q <= stall_q + 16'd1;
        end
    end

    assign grant_cnt = gcnt_q;
    assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_refill_arbiter.sv
// tb_refill_arbiter: directed checks of grant order, latency, timeout, drop, reset and stats.
module tb_refill_arbiter;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic [3:0]   core_req = '0;
    logic [127:0] core_addr;
    logic [3:0]   core_grant, core_done;
    logic         core_err, mem_start, mem_ready = 1'b0, busy;
    logic [127:0] core_block, mem_block = '0;
    logic [31:0]  mem_addr;
`ifdef REFILL_ARB_STATS_EN
    logic [63:0]  grant_cnt;
    logic [15:0]  stall_cnt;
`endif

    int errors = 0;
    int checks = 0;

    refill_arbiter #(
        .NUM_CORES(4), .ADDR_W(32), .BLOCK_SIZE_BYTE(16), .WAIT_MAX(8)
    ) dut (
        .clock(clock), .reset(reset), .core_req(core_req), .core_addr(core_addr),
        .core_grant(core_grant), .core_done(core_done), .core_err(core_err),
        .core_block(core_block), .mem_start(mem_start), .mem_addr(mem_addr),
        .mem_block(mem_block), .mem_ready(mem_ready), .busy(busy)
`ifdef REFILL_ARB_STATS_EN
        , .grant_cnt(grant_cnt), .stall_cnt(stall_cnt)
`endif
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] addr_of(input int i);
        return 32'hA000_0000 + 32'(i) * 32'h100;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One refill with data returned in the first WAIT cycle; starts and ends in IDLE.
    task automatic do_refill(input string tag, input logic [3:0] exp_g, input logic [3:0] drop,
                             input logic [127:0] blk);
        int w = 0;
        for (int i = 0; i < 4; i++) if (exp_g[i]) w = i;
        tick();
        chk({tag, "_grant"}, core_grant, exp_g);
        chk({tag, "_start"}, mem_start, 1'b1);
        chk({tag, "_addr"}, mem_addr, addr_of(w));
        tick();
        chk({tag, "_start_once"}, mem_start, 1'b0);
        core_req  = core_req & ~drop;
        mem_ready = 1'b1;
        mem_block = blk;
        tick();
        mem_ready = 1'b0;
        chk({tag, "_done"}, core_done, exp_g);
        chk({tag, "_err"}, core_err, 1'b0);
        chk({tag, "_block"}, core_block, blk);
        chk({tag, "_grant_clr"}, core_grant, 4'b0000);
        tick();
        chk({tag, "_done_clr"}, core_done, 4'b0000);
        chk({tag, "_idle"}, busy, 1'b0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 4; i++) core_addr[i*32 +: 32] = addr_of(i);
        do_reset();
        chk("rst_busy", busy, 1'b0);
        chk("rst_grant", core_grant, 4'b0000);
        chk("rst_done", core_done, 4'b0000);
        chk("rst_start", mem_start, 1'b0);
        chk("rst_block", core_block, 128'h0);
        chk("rst_addr", mem_addr, 32'h0);
        chk("rst_err", core_err, 1'b0);

        // T1: single core, minimum latency
        core_req = 4'b0001;
        do_refill("t1", 4'b0001, 4'b0000, {4{32'h1111_0001}});
        core_req = 4'b0000;

        // T2: all cores held, rotation from pointer 0
        do_reset();
        core_req = 4'b1111;
        do_refill("t2a", 4'b0001, 4'b0000, {4{32'h2222_0000}});
        do_refill("t2b", 4'b0010, 4'b0000, {4{32'h2222_0001}});
        do_refill("t2c", 4'b0100, 4'b0000, {4{32'h2222_0002}});
        do_refill("t2d", 4'b1000, 4'b0000, {4{32'h2222_0003}});
        do_refill("t2e", 4'b0001, 4'b0000, {4{32'h2222_0004}});
        core_req = 4'b0000;

        // T3: timeout, pointer now 1, core2 alone wins
        core_req = 4'b0100;
        tick();
        chk("t3_grant", core_grant, 4'b0100);
        tick();
        for (int k = 0; k < 7; k++) tick();
        chk("t3_not_yet", core_done, 4'b0000);
        chk("t3_busy", busy, 1'b1);
        tick();
        chk("t3_done", core_done, 4'b0100);
        chk("t3_err", core_err, 1'b1);
        chk("t3_block_kept", core_block, {4{32'h2222_0004}});
        core_req = 4'b0000;
        tick();
        chk("t3_idle", busy, 1'b0);
        chk("t3_err_clr", core_err, 1'b0);

        // mem_ready while idle is ignored
        mem_ready = 1'b1;
        mem_block = {4{32'hBAD0_BAD0}};
        tick();
        mem_ready = 1'b0;
        chk("idle_ready_busy", busy, 1'b0);
        chk("idle_ready_done", core_done, 4'b0000);
        chk("idle_ready_block", core_block, {4{32'h2222_0004}});

        // ready on the final timeout cycle: ready wins
        core_req = 4'b0001;
        tick();
        chk("tie_grant", core_grant, 4'b0001);
        tick();
        for (int k = 0; k < 7; k++) tick();
        mem_ready = 1'b1;
        mem_block = {4{32'h3333_0000}};
        tick();
        mem_ready = 1'b0;
        chk("tie_done", core_done, 4'b0001);
        chk("tie_err", core_err, 1'b0);
        chk("tie_block", core_block, {4{32'h3333_0000}});
        core_req = 4'b0000;
        tick();

        // T4: pointer 1, core2 wins then drops; next goes to core3 not core0
        core_req = 4'b1101;
        do_refill("t4a", 4'b0100, 4'b0100, {4{32'h4444_0002}});
        chk("t4_req_dropped", core_req, 4'b1001);
        do_refill("t4b", 4'b1000, 4'b0000, {4{32'h4444_0003}});
        core_req = 4'b0000;

        // T5: move pointer to 2, then reset mid-WAIT with core3 in flight
        core_req = 4'b0010;
        do_refill("t5pre", 4'b0010, 4'b0000, {4{32'h5555_0001}});
        core_req = 4'b1000;
        tick();
        chk("t5_grant", core_grant, 4'b1000);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        core_req = 4'b0000;
        chk("t5_busy", busy, 1'b0);
        chk("t5_grant_clr", core_grant, 4'b0000);
        chk("t5_done", core_done, 4'b0000);
        mem_ready = 1'b1;
        mem_block = {4{32'hBAD1_BAD1}};
        tick();
        mem_ready = 1'b0;
        chk("t5_late_done", core_done, 4'b0000);
        chk("t5_late_busy", busy, 1'b0);
        chk("t5_late_block", core_block, 128'h0);
        core_req = 4'b1111;
        do_refill("t5_ptr0", 4'b0001, 4'b0000, {4{32'h5555_0000}});
        core_req = 4'b0000;

`ifdef REFILL_ARB_STATS_EN
        // T6: completion counters
        do_reset();
        core_req = 4'b0010;
        for (int k = 0; k < 5; k++) do_refill("t6c1", 4'b0010, 4'b0000, 128'(k));
        core_req = 4'b1000;
        for (int k = 0; k < 3; k++) do_refill("t6c3", 4'b1000, 4'b0000, 128'(k + 8));
        core_req = 4'b0000;
        chk("t6_cnt0", grant_cnt[15:0], 16'd0);
        chk("t6_cnt1", grant_cnt[31:16], 16'd5);
        chk("t6_cnt2", grant_cnt[47:32], 16'd0);
        chk("t6_cnt3", grant_cnt[63:48], 16'd3);
        chk("t6_stall", stall_cnt, 16'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
